// File: rtl/pipeline_stall_scheduler_if.sv
// pipeline_stall_scheduler_if: bundles the ID, WB, MEM and EXE hazard inputs
// and the freeze/flush controls exchanged with the stall scheduler.
//   master : pipeline side (drives hazard inputs, receives controls)
//   slave  : scheduler side (receives hazard inputs, drives controls)
// CNT_W sets the width of stall_cnt.
interface pipeline_stall_scheduler_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             id_valid;
  logic [3:0]       id_src1;
  logic [3:0]       id_src2;
  logic             id_two_src;
  logic             id_wb_en;
  logic [3:0]       id_dest;
  logic             id_mem_r_en;
  logic             fwd_en;
  logic             wb_valid;
  logic [3:0]       wb_dest;
  logic             mem_req;
  logic             mem_ready;
  logic             branch_taken;

  logic             freeze_if;
  logic             freeze_id;
  logic             bubble_exe;
  logic             freeze_pipe;
  logic             flush;
  logic             issue;
  logic             mem_err;
  logic [15:0]      pending_mask;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, fwd_en, wb_valid, wb_dest, mem_req, mem_ready,
           branch_taken,
    input  freeze_if, freeze_id, bubble_exe, freeze_pipe, flush, issue,
           mem_err, pending_mask, stall_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest,
           id_mem_r_en, fwd_en, wb_valid, wb_dest, mem_req, mem_ready,
           branch_taken,
    output freeze_if, freeze_id, bubble_exe, freeze_pipe, flush, issue,
           mem_err, pending_mask, stall_cnt
  );
endinterface

// File: rtl/pipeline_stall_scheduler.sv
// pipeline_stall_scheduler: central stall/flush scheduler for the 5-stage
// pipeline. A 16-entry scoreboard (pending + load bits) detects RAW hazards
// at ID, a two-state wait FSM with timeout freezes the whole pipe while the
// data SRAM is busy, and taken branches seen during a freeze are deferred
// until the pipe unfreezes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - pipeline_stall_scheduler_if.slave (hazard inputs, controls out)
// Parameters:
//   MEM_TIMEOUT - frozen cycles in M_WAIT before aborting (2..65535)
//   CNT_W       - width of stall_cnt
// Optional feature macro: STALL_PERF_CNT_EN (saturating stall-cycle counter;
// when undefined stall_cnt is tied to 0).
module pipeline_stall_scheduler #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input logic                      clk,
  input logic                      rst,
  pipeline_stall_scheduler_if.slave bus
);

  localparam int unsigned NREG   = 16;
  localparam int unsigned TCNT_W = 16;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

  mem_state_e        state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              mem_err_q, mem_err_d;
  logic              defer_q, defer_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [NREG-1:0]   ld_q, ld_d;

  logic freeze_pipe_w;
  logic haz_src1, haz_src2, hazard;
  logic flush_raw, issue_raw, stall_raw;

  // Hazard decode uses registered scoreboard state only (no WB bypass).
  always_comb begin
    haz_src1 = pend_q[bus.id_src1] & (~bus.fwd_en | ld_q[bus.id_src1]);
    haz_src2 = bus.id_two_src & pend_q[bus.id_src2] &
               (~bus.fwd_en | ld_q[bus.id_src2]);
    hazard   = bus.id_valid & (haz_src1 | haz_src2);
  end

  // Internal (ungated) control terms; flush overrides hazard.
  assign freeze_pipe_w = (state_q == M_WAIT);
  assign flush_raw     = (bus.branch_taken | defer_q) & ~freeze_pipe_w;
  assign stall_raw     = hazard & ~freeze_pipe_w & ~flush_raw;
  assign issue_raw     = bus.id_valid & ~hazard & ~freeze_pipe_w & ~flush_raw;

  // Outputs forced low while reset is held.
  assign bus.freeze_if    = rst & stall_raw;
  assign bus.freeze_id    = rst & stall_raw;
  assign bus.bubble_exe   = rst & stall_raw;
  assign bus.flush        = rst & flush_raw;
  assign bus.issue        = rst & issue_raw;
  assign bus.freeze_pipe  = freeze_pipe_w;
  assign bus.mem_err      = mem_err_q;
  assign bus.pending_mask = pend_q;

  // Scoreboard next state: clear first so a same-cycle set wins.
  always_comb begin
    pend_d = pend_q;
    ld_d   = ld_q;
    if (bus.wb_valid & ~freeze_pipe_w) begin
      pend_d[bus.wb_dest] = 1'b0;
      ld_d[bus.wb_dest]   = 1'b0;
    end
    if (issue_raw & bus.id_wb_en) begin
      pend_d[bus.id_dest] = 1'b1;
      ld_d[bus.id_dest]   = bus.id_mem_r_en;
    end
  end

  // Memory wait FSM and deferred-flush next state.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    mem_err_d = 1'b0;
    defer_d   = defer_q;

    case (state_q)
      M_IDLE: begin
        if (bus.mem_req & ~bus.mem_ready) begin
          state_d = M_WAIT;
          tcnt_d  = TCNT_W'(1);
        end
      end
      M_WAIT: begin
        if (bus.mem_ready) begin
          state_d = M_IDLE;
        end else if (tcnt_q == TCNT_W'(MEM_TIMEOUT)) begin
          state_d   = M_IDLE;
          mem_err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end
      default: state_d = M_IDLE;
    endcase

    if (flush_raw) begin
      defer_d = 1'b0;
    end else if (bus.branch_taken & freeze_pipe_w) begin
      defer_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= M_IDLE;
      tcnt_q    <= '0;
      mem_err_q <= 1'b0;
      defer_q   <= 1'b0;
      pend_q    <= '0;
      ld_q      <= '0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      mem_err_q <= mem_err_d;
      defer_q   <= defer_d;
      pend_q    <= pend_d;
      ld_q      <= ld_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [CNT_W-1:0] scnt_q;

  // Saturating count of cycles with an ID stall or an SRAM freeze.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scnt_q <= '0;
    end else if ((stall_raw | freeze_pipe_w) && (scnt_q != '1)) begin
      scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = scnt_q;
`else
  assign bus.stall_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_stall_scheduler.sv
// Self-checking bench for pipeline_stall_scheduler: directed scenarios
// followed by randomized traffic, all compared against a cycle model kept
// as plain arrays and counters.
module tb_pipeline_stall_scheduler;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst;

  pipeline_stall_scheduler_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_scheduler #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit             m_pend [16];
  bit             m_ld   [16];
  bit             m_waiting;
  int             m_frozen;
  bit             m_defer;
  bit             m_err;
  bit [CNT_W-1:0] m_scnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = 1'b0;
      m_ld[i]   = 1'b0;
    end
    m_waiting = 1'b0;
    m_frozen  = 0;
    m_defer   = 1'b0;
    m_err     = 1'b0;
    m_scnt    = '0;
  endtask

  function automatic bit src_hazard(input logic [3:0] s);
    return m_pend[s] && (!bus.fwd_en || m_ld[s]);
  endfunction

  task automatic idle_inputs();
    bus.id_valid     = 1'b0;
    bus.id_src1      = 4'd0;
    bus.id_src2      = 4'd0;
    bus.id_two_src   = 1'b0;
    bus.id_wb_en     = 1'b0;
    bus.id_dest      = 4'd0;
    bus.id_mem_r_en  = 1'b0;
    bus.fwd_en       = 1'b1;
    bus.wb_valid     = 1'b0;
    bus.wb_dest      = 4'd0;
    bus.mem_req      = 1'b0;
    bus.mem_ready    = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  task automatic set_id(input bit v, input logic [3:0] s1, input logic [3:0] s2,
                        input bit two, input bit wb, input logic [3:0] d,
                        input bit ldr);
    bus.id_valid    = v;
    bus.id_src1     = s1;
    bus.id_src2     = s2;
    bus.id_two_src  = two;
    bus.id_wb_en    = wb;
    bus.id_dest     = d;
    bus.id_mem_r_en = ldr;
  endtask

  // One cycle: check outputs against the model mid-cycle, then advance the
  // model on the rising edge using the same inputs.
  task automatic tick(input string tag);
    bit          e_fp, e_hz, e_fl, e_iss, e_fz, nxt_err;
    logic [15:0] e_mask;
    @(negedge clk);
    e_fp  = m_waiting;
    e_hz  = bus.id_valid && (src_hazard(bus.id_src1) ||
                             (bus.id_two_src && src_hazard(bus.id_src2)));
    e_fl  = (bus.branch_taken || m_defer) && !e_fp;
    e_iss = bus.id_valid && !e_hz && !e_fp && !e_fl;
    e_fz  = e_hz && !e_fp && !e_fl;
    for (int i = 0; i < 16; i++) e_mask[i] = m_pend[i];

    chk({tag, ".freeze_if"},   32'(bus.freeze_if),    32'(e_fz));
    chk({tag, ".freeze_id"},   32'(bus.freeze_id),    32'(e_fz));
    chk({tag, ".bubble_exe"},  32'(bus.bubble_exe),   32'(e_fz));
    chk({tag, ".freeze_pipe"}, 32'(bus.freeze_pipe),  32'(e_fp));
    chk({tag, ".flush"},       32'(bus.flush),        32'(e_fl));
    chk({tag, ".issue"},       32'(bus.issue),        32'(e_iss));
    chk({tag, ".mem_err"},     32'(bus.mem_err),      32'(m_err));
    chk({tag, ".pending"},     32'(bus.pending_mask), 32'(e_mask));
`ifdef STALL_PERF_CNT_EN
    chk({tag, ".stall_cnt"},   32'(bus.stall_cnt),    32'(m_scnt));
`else
    chk({tag, ".stall_cnt"},   32'(bus.stall_cnt),    32'd0);
`endif

    @(posedge clk);
    if (!e_fp) begin
      if (bus.wb_valid) begin
        m_pend[bus.wb_dest] = 1'b0;
        m_ld[bus.wb_dest]   = 1'b0;
      end
      if (e_iss && bus.id_wb_en) begin
        m_pend[bus.id_dest] = 1'b1;
        m_ld[bus.id_dest]   = bus.id_mem_r_en;
      end
    end
    nxt_err = 1'b0;
    if (!m_waiting) begin
      if (bus.mem_req && !bus.mem_ready) begin
        m_waiting = 1'b1;
        m_frozen  = 0;
      end
    end else begin
      m_frozen++;
      if (bus.mem_ready) begin
        m_waiting = 1'b0;
      end else if (m_frozen == int'(MEM_TIMEOUT)) begin
        m_waiting = 1'b0;
        nxt_err   = 1'b1;
      end
    end
    m_err = nxt_err;
    if (e_fl) m_defer = 1'b0;
    else if (bus.branch_taken && e_fp) m_defer = 1'b1;
    if ((e_fz || e_fp) && (m_scnt != '1)) m_scnt = m_scnt + CNT_W'(1);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".freeze_if"},   32'(bus.freeze_if),    32'd0);
    chk({tag, ".freeze_id"},   32'(bus.freeze_id),    32'd0);
    chk({tag, ".bubble_exe"},  32'(bus.bubble_exe),   32'd0);
    chk({tag, ".freeze_pipe"}, 32'(bus.freeze_pipe),  32'd0);
    chk({tag, ".flush"},       32'(bus.flush),        32'd0);
    chk({tag, ".issue"},       32'(bus.issue),        32'd0);
    chk({tag, ".mem_err"},     32'(bus.mem_err),      32'd0);
    chk({tag, ".pending"},     32'(bus.pending_mask), 32'd0);
    chk({tag, ".stall_cnt"},   32'(bus.stall_cnt),    32'd0);
  endtask

  initial begin
    // Reset with active inputs: every output must still read 0.
    rst = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b0);
    bus.branch_taken = 1'b1;
    #1;
    check_all_zero("reset");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Load-use: LDR R3 then a reader of R3 stalls until the WB clear retires.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1);
    tick("ldr_r3");
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (2) tick("use_r3");
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 4'd3;
    tick("wb_r3");
    bus.wb_valid = 1'b0;
    tick("rel_r3");
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick("idle0");

    // ALU result with forwarding: no stall; without forwarding: stall.
    bus.fwd_en = 1'b1;
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0);
    tick("add_r4_fwd");
    set_id(1'b1, 4'd4, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0);
    tick("sub_r4_fwd");
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 4'd4;
    tick("wb_r4_a");
    bus.wb_dest  = 4'd7;
    tick("wb_r7");
    bus.wb_valid = 1'b0;
    bus.fwd_en   = 1'b0;
    set_id(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0);
    tick("add_r4_nofwd");
    set_id(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (2) tick("sub_r4_nofwd");
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 4'd4;
    tick("wb_r4_b");
    bus.wb_valid = 1'b0;
    tick("rel_r4");

    // src2 only counts when id_two_src is set.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0);
    tick("set_r5");
    set_id(1'b1, 4'd1, 4'd5, 1'b0, 1'b0, 4'd0, 1'b0);
    tick("r5_one_src");
    set_id(1'b1, 4'd1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0);
    tick("r5_two_src");
    // Same-cycle set and clear of R6: the set must win.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0);
    bus.fwd_en   = 1'b1;
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 4'd6;
    tick("set_clr_r6");
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.wb_dest  = 4'd5;
    tick("clr_r5");
    bus.wb_dest  = 4'd6;
    tick("clr_r6");
    bus.wb_dest  = 4'd9;
    tick("clr_idle_r9");
    bus.wb_valid = 1'b0;

    // SRAM wait: ready low 5 cycles, then ready; then a zero-wait access.
    bus.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) tick("mem_wait");
    bus.mem_ready = 1'b1;
    tick("mem_ready");
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    tick("mem_idle");
    bus.mem_req = 1'b1;
    bus.mem_ready = 1'b1;
    tick("mem_fast");
    bus.mem_req = 1'b0;
    bus.mem_ready = 1'b0;
    tick("mem_idle2");

    // Timeout with a branch arriving mid-freeze: flush deferred.
    bus.mem_req = 1'b1;
    tick("to_enter");
    tick("to_w1");
    bus.branch_taken = 1'b1;
    tick("to_w2_br");
    bus.branch_taken = 1'b0;
    tick("to_w3");
    tick("to_w4");
    bus.mem_req = 1'b0;
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b0);
    tick("to_err_flush");
    tick("to_after");
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_dest  = 4'd2;
    tick("clr_r2");
    bus.wb_dest  = 4'd6;
    tick("clr_r6b");
    bus.wb_valid = 1'b0;

    // Async reset in the middle of M_WAIT with R3 and R4 pending.
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b0);
    tick("pre_r3");
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1);
    tick("pre_r4");
    set_id(1'b1, 4'd3, 4'd4, 1'b1, 1'b0, 4'd0, 1'b0);
    bus.mem_req = 1'b1;
    tick("pre_wait0");
    tick("pre_wait1");
    chk("pre_rst.pending", 32'(bus.pending_mask), 32'h0018);
    chk("pre_rst.freeze_pipe", 32'(bus.freeze_pipe), 32'd1);
    bus.branch_taken = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick("post_rst");

    // Randomized traffic over a small register window to force hazards.
    for (int n = 0; n < 400; n++) begin
      set_id(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)),
             4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
             4'($urandom_range(0, 7)), 1'($urandom));
      if ($urandom_range(0, 15) == 0) bus.fwd_en = ~bus.fwd_en;
      bus.wb_valid     = ($urandom_range(0, 9) < 4);
      bus.wb_dest      = 4'($urandom_range(0, 7));
      bus.mem_req      = ($urandom_range(0, 4) == 0);
      bus.mem_ready    = ($urandom_range(0, 2) == 0);
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
